// File: rtl/axi4_burst_addr_gen_if.sv
// Command/beat bundle for axi4_burst_addr_gen: master drives commands and
// consumes beats, slave is the generator itself.
interface axi4_burst_addr_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [1:0]            cmd_burst;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [STRB_WIDTH-1:0] beat_strb;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic                  beat_err;

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx,
           beat_last, beat_err
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx,
           beat_last, beat_err
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address generator: expands one AW/AR command into per-beat
// address/strobe/index/last. Define AXI4_BURST_CHECK_EN to build the beat_err checker.
module axi4_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi4_burst_addr_gen_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LOG2_STRB  = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   beat_id_q, beat_id_d;
  logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
  logic [STRB_WIDTH-1:0] beat_strb_q, beat_strb_d;
  logic [7:0]            beat_idx_q, beat_idx_d;
  logic                  beat_last_q, beat_last_d;
  logic                  beat_err_q, beat_err_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] wrap_lower_q, wrap_lower_d;
  logic [ADDR_WIDTH-1:0] wrap_bound_q, wrap_bound_d;

  logic                  beat_valid;
  logic                  beat_fire;
  logic                  cmd_ready;
  logic                  cmd_fire;
  logic                  cmd_err;
  logic                  strb_load;
  logic [ADDR_WIDTH-1:0] cmd_total;
  logic [ADDR_WIDTH-1:0] cur_nbytes, cur_aligned, wrap_next, adv_addr;
  logic [ADDR_WIDTH-1:0] nxt_nbytes, lane_lo, lane_hi;
  logic [STRB_WIDTH-1:0] nxt_strb;

  // Wrap window size in bytes: (len+1) beats of 2^size bytes.
  always_comb begin
    cmd_total = ADDR_WIDTH'({1'b0, bus.cmd_len} + 9'd1) << bus.cmd_size;
  end

`ifdef AXI4_BURST_CHECK_EN
  logic [7:0]  chk_nbytes;
  logic [11:0] chk_low12;
  logic [16:0] chk_span;
  logic        wrap_len_bad, wrap_unaligned, burst_rsvd, size_too_big, incr_4k_cross;

  always_comb begin
    chk_nbytes     = 8'd1 << bus.cmd_size;
    chk_low12      = bus.cmd_addr[11:0] & ~{4'b0, chk_nbytes - 8'd1};
    chk_span       = {5'b0, chk_low12} + {1'b0, cmd_total[15:0]};
    wrap_len_bad   = (bus.cmd_burst == BURST_WRAP) &&
                     !(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15});
    wrap_unaligned = (bus.cmd_burst == BURST_WRAP) &&
                     (|(bus.cmd_addr[7:0] & (chk_nbytes - 8'd1)));
    burst_rsvd     = (bus.cmd_burst == 2'b11);
    size_too_big   = (int'(bus.cmd_size) > LOG2_STRB);
    incr_4k_cross  = (bus.cmd_burst == BURST_INCR) && (chk_span > 17'd4096);
    cmd_err        = wrap_len_bad || wrap_unaligned || burst_rsvd ||
                     size_too_big || incr_4k_cross;
  end
`else
  assign cmd_err = 1'b0;
`endif

  // Address of the beat after the current one, from the latched burst shape.
  always_comb begin
    cur_nbytes  = ONE << size_q;
    cur_aligned = beat_addr_q & ~(cur_nbytes - ONE);
    wrap_next   = beat_addr_q + cur_nbytes;
    case (burst_q)
      BURST_FIXED: adv_addr = beat_addr_q;
      BURST_WRAP:  adv_addr = (wrap_next == wrap_bound_q) ? wrap_lower_q : wrap_next;
      default:     adv_addr = cur_aligned + cur_nbytes;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    beat_id_d    = beat_id_q;
    beat_addr_d  = beat_addr_q;
    beat_idx_d   = beat_idx_q;
    beat_last_d  = beat_last_q;
    beat_err_d   = beat_err_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    wrap_lower_d = wrap_lower_q;
    wrap_bound_d = wrap_bound_q;
    strb_load    = 1'b0;

    beat_valid = (state_q == BURST);
    beat_fire  = beat_valid && bus.beat_ready;
    // Accepting on the last-beat handshake gives back-to-back bursts.
    cmd_ready  = (state_q == IDLE) || (beat_fire && beat_last_q);
    cmd_fire   = bus.cmd_valid && cmd_ready;

    if (cmd_fire) begin
      state_d      = BURST;
      beat_id_d    = bus.cmd_id;
      beat_addr_d  = bus.cmd_addr;
      beat_idx_d   = 8'd0;
      beat_last_d  = (bus.cmd_len == 8'd0);
      beat_err_d   = cmd_err;
      len_d        = bus.cmd_len;
      size_d       = bus.cmd_size;
      burst_d      = bus.cmd_burst;
      wrap_lower_d = bus.cmd_addr & ~(cmd_total - ONE);
      wrap_bound_d = wrap_lower_d + cmd_total;
      strb_load    = 1'b1;
    end else if (beat_fire) begin
      if (beat_last_q) begin
        state_d = IDLE;
      end else begin
        beat_addr_d = adv_addr;
        beat_idx_d  = beat_idx_q + 8'd1;
        beat_last_d = ((beat_idx_q + 8'd1) == len_q);
        strb_load   = 1'b1;
      end
    end
  end

  // Lane window of the upcoming beat; oversized beats clamp to the top lane.
  always_comb begin
    nxt_nbytes = ONE << size_d;
    lane_lo    = beat_addr_d & LANE_MASK;
    if (int'(size_d) > LOG2_STRB) begin
      lane_hi = LANE_MASK;
    end else begin
      lane_hi = (beat_addr_d & ~(nxt_nbytes - ONE) & LANE_MASK) + nxt_nbytes - ONE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STRB_WIDTH; gi = gi + 1) begin : g_lane
      assign nxt_strb[gi] = (ADDR_WIDTH'(gi) >= lane_lo) && (ADDR_WIDTH'(gi) <= lane_hi);
    end
  endgenerate

  always_comb begin
    beat_strb_d = strb_load ? nxt_strb : beat_strb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_id_q    <= '0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_idx_q   <= '0;
      beat_last_q  <= 1'b0;
      beat_err_q   <= 1'b0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      wrap_lower_q <= '0;
      wrap_bound_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_id_q    <= beat_id_d;
      beat_addr_q  <= beat_addr_d;
      beat_strb_q  <= beat_strb_d;
      beat_idx_q   <= beat_idx_d;
      beat_last_q  <= beat_last_d;
      beat_err_q   <= beat_err_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      wrap_lower_q <= wrap_lower_d;
      wrap_bound_q <= wrap_bound_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.beat_valid = beat_valid;
  assign bus.beat_id    = beat_id_q;
  assign bus.beat_addr  = beat_addr_q;
  assign bus.beat_strb  = beat_strb_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = beat_last_q;
  assign bus.beat_err   = beat_err_q;
endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Directed bench for axi4_burst_addr_gen (64-bit data, 32-bit address, 8-bit ID);
// beat_err expectations follow whether AXI4_BURST_CHECK_EN is defined.
module tb_axi4_burst_addr_gen;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

`ifdef AXI4_BURST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  axi4_burst_addr_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(8)) bus_if ();

  axi4_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_id    = id;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_len   = len;
    bus_if.cmd_size  = size;
    bus_if.cmd_burst = burst;
    $display("cmd id=%0h addr=0x%0h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
  endtask

  task automatic check_beat(input string tag, input logic [7:0] id, input logic [31:0] addr,
                            input logic [7:0] strb, input logic [7:0] idx, input logic last,
                            input logic err);
    chk({tag, ".valid"}, 64'(bus_if.beat_valid), 64'(1'b1));
    chk({tag, ".id"},    64'(bus_if.beat_id),    64'(id));
    chk({tag, ".addr"},  64'(bus_if.beat_addr),  64'(addr));
    chk({tag, ".strb"},  64'(bus_if.beat_strb),  64'(strb));
    chk({tag, ".idx"},   64'(bus_if.beat_idx),   64'(idx));
    chk({tag, ".last"},  64'(bus_if.beat_last),  64'(last));
    chk({tag, ".err"},   64'(bus_if.beat_err),   64'(err));
    $display("beat %s id=%0h addr=0x%0h strb=0x%0h idx=%0d last=%0b err=%0b", tag,
             bus_if.beat_id, bus_if.beat_addr, bus_if.beat_strb, bus_if.beat_idx,
             bus_if.beat_last, bus_if.beat_err);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_id     = '0;
    bus_if.cmd_addr   = '0;
    bus_if.cmd_len    = '0;
    bus_if.cmd_size   = '0;
    bus_if.cmd_burst  = '0;
    bus_if.beat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst.cmd_ready", 64'(bus_if.cmd_ready),  64'(1'b1));
    chk("rst.valid",     64'(bus_if.beat_valid), 64'(1'b0));
    chk("rst.addr",      64'(bus_if.beat_addr),  64'(0));
    chk("rst.strb",      64'(bus_if.beat_strb),  64'(0));
    chk("rst.idx",       64'(bus_if.beat_idx),   64'(0));
    chk("rst.id",        64'(bus_if.beat_id),    64'(0));
    chk("rst.last",      64'(bus_if.beat_last),  64'(1'b0));
    chk("rst.err",       64'(bus_if.beat_err),   64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("idle.valid", 64'(bus_if.beat_valid), 64'(1'b0));

    // INCR, unaligned start
    bus_if.beat_ready = 1'b1;
    send_cmd(8'h01, 32'h1003, 8'd3, 3'd2, 2'b01);
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("incr0", 8'h01, 32'h1003, 8'h08, 8'd0, 1'b0, 1'b0);
    cyc();
    check_beat("incr1", 8'h01, 32'h1004, 8'hF0, 8'd1, 1'b0, 1'b0);
    cyc();
    check_beat("incr2", 8'h01, 32'h1008, 8'h0F, 8'd2, 1'b0, 1'b0);
    cyc();
    check_beat("incr3", 8'h01, 32'h100C, 8'hF0, 8'd3, 1'b1, 1'b0);
    cyc();
    chk("incr.done_valid", 64'(bus_if.beat_valid), 64'(1'b0));

    // WRAP
    send_cmd(8'h05, 32'h2018, 8'd3, 3'd3, 2'b10);
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("wrap0", 8'h05, 32'h2018, 8'hFF, 8'd0, 1'b0, 1'b0);
    cyc();
    check_beat("wrap1", 8'h05, 32'h2000, 8'hFF, 8'd1, 1'b0, 1'b0);
    cyc();
    check_beat("wrap2", 8'h05, 32'h2008, 8'hFF, 8'd2, 1'b0, 1'b0);
    cyc();
    check_beat("wrap3", 8'h05, 32'h2010, 8'hFF, 8'd3, 1'b1, 1'b0);
    cyc();

    // FIXED, then a back-to-back command on the last beat
    send_cmd(8'h07, 32'h40, 8'd2, 3'd1, 2'b00);
    cyc();
    bus_if.cmd_valid = 1'b0;
    #1;
    chk("fixed.cmd_ready_mid", 64'(bus_if.cmd_ready), 64'(1'b0));
    check_beat("fixed0", 8'h07, 32'h40, 8'h03, 8'd0, 1'b0, 1'b0);
    cyc();
    check_beat("fixed1", 8'h07, 32'h40, 8'h03, 8'd1, 1'b0, 1'b0);
    cyc();
    check_beat("fixed2", 8'h07, 32'h40, 8'h03, 8'd2, 1'b1, 1'b0);
    send_cmd(8'h08, 32'h80, 8'd0, 3'd3, 2'b01);
    #1;
    chk("b2b.cmd_ready_last", 64'(bus_if.cmd_ready), 64'(1'b1));
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("b2b0", 8'h08, 32'h80, 8'hFF, 8'd0, 1'b1, 1'b0);
    cyc();
    chk("b2b.done_valid", 64'(bus_if.beat_valid), 64'(1'b0));

    // Backpressure: ready 1,0,0,1
    send_cmd(8'h09, 32'h100, 8'd3, 3'd2, 2'b01);
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("bp0", 8'h09, 32'h100, 8'h0F, 8'd0, 1'b0, 1'b0);
    cyc();
    check_beat("bp1", 8'h09, 32'h104, 8'hF0, 8'd1, 1'b0, 1'b0);
    bus_if.beat_ready = 1'b0;
    cyc();
    check_beat("bp1_hold_a", 8'h09, 32'h104, 8'hF0, 8'd1, 1'b0, 1'b0);
    cyc();
    check_beat("bp1_hold_b", 8'h09, 32'h104, 8'hF0, 8'd1, 1'b0, 1'b0);
    bus_if.beat_ready = 1'b1;
    cyc();
    check_beat("bp2", 8'h09, 32'h108, 8'h0F, 8'd2, 1'b0, 1'b0);
    cyc();
    check_beat("bp3", 8'h09, 32'h10C, 8'hF0, 8'd3, 1'b1, 1'b0);
    cyc();

    // Asynchronous reset in the middle of a len=7 burst
    send_cmd(8'h11, 32'h200, 8'd7, 3'd3, 2'b01);
    cyc();
    bus_if.cmd_valid = 1'b0;
    cyc();
    cyc();
    check_beat("rstmid2", 8'h11, 32'h210, 8'hFF, 8'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.valid",     64'(bus_if.beat_valid), 64'(1'b0));
    chk("rstmid.idx",       64'(bus_if.beat_idx),   64'(0));
    chk("rstmid.addr",      64'(bus_if.beat_addr),  64'(0));
    chk("rstmid.cmd_ready", 64'(bus_if.cmd_ready),  64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    send_cmd(8'h12, 32'h300, 8'd1, 3'd2, 2'b01);
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("post0", 8'h12, 32'h300, 8'h0F, 8'd0, 1'b0, 1'b0);
    cyc();
    check_beat("post1", 8'h12, 32'h304, 8'hF0, 8'd1, 1'b1, 1'b0);
    cyc();

    // INCR crossing 4 KB
    send_cmd(8'h20, 32'hFF8, 8'd1, 3'd3, 2'b01);
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("x4k0", 8'h20, 32'hFF8, 8'hFF, 8'd0, 1'b0, EXP_ERR);
    cyc();
    check_beat("x4k1", 8'h20, 32'h1000, 8'hFF, 8'd1, 1'b1, EXP_ERR);
    cyc();

    // WRAP with len=2 (illegal length, still expanded)
    send_cmd(8'h21, 32'h10, 8'd2, 3'd2, 2'b10);
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("wlen0", 8'h21, 32'h10, 8'h0F, 8'd0, 1'b0, EXP_ERR);
    cyc();
    check_beat("wlen1", 8'h21, 32'h14, 8'hF0, 8'd1, 1'b0, EXP_ERR);
    cyc();
    check_beat("wlen2", 8'h21, 32'h18, 8'h0F, 8'd2, 1'b1, EXP_ERR);
    cyc();

    // Beat wider than the bus: strobe clamps to the top lane
    send_cmd(8'h22, 32'h23, 8'd1, 3'd4, 2'b01);
    cyc();
    bus_if.cmd_valid = 1'b0;
    check_beat("wide0", 8'h22, 32'h23, 8'hF8, 8'd0, 1'b0, EXP_ERR);
    cyc();
    check_beat("wide1", 8'h22, 32'h30, 8'hFF, 8'd1, 1'b1, EXP_ERR);
    cyc();
    chk("end.valid", 64'(bus_if.beat_valid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
